// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller for a 5-stage pipeline (memory freeze, branch flush, load-use bubble, stall counter)
module pipe_hazard_ctrl #(
  parameter int MEM_LAT    = 2,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_br_taken,
  input  logic                  mem_access,
  output logic                  pc_ld_n,
  output logic                  if_id_ld_n,
  output logic                  id_ex_ld_n,
  output logic                  ex_mem_ld_n,
  output logic                  mem_wb_ld_n,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  mem_wb_flush,
  output logic                  mem_busy,
  output logic [CNT_W-1:0]      stall_count
);
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic LONG = (MEM_LAT >= 2);
  localparam logic [CW-1:0] LOAD = CW'((MEM_LAT >= 2) ? MEM_LAT - 2 : 0);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [CNT_W-1:0] r_stall_count;
  logic w_lu, w_freeze, w_lu_stall;
  always_comb begin
    w_lu = ex_mem_read && (ex_rd != '0) &&
           ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    w_freeze = (r_state == RUN && mem_access && LONG) || (r_state == MEM_WAIT && r_cnt != '0);
    // a taken branch squashes the ID instruction, so its hazard no longer matters
    w_lu_stall = !w_freeze && !ex_br_taken && w_lu;
    pc_ld_n      = clr || w_freeze || w_lu_stall;
    if_id_ld_n   = clr || w_freeze || w_lu_stall;
    id_ex_ld_n   = clr || w_freeze;
    ex_mem_ld_n  = clr || w_freeze;
    mem_wb_ld_n  = clr;
    if_id_flush  = !clr && !w_freeze && ex_br_taken;
    id_ex_flush  = !clr && !w_freeze && (ex_br_taken || w_lu);
    mem_wb_flush = !clr && w_freeze;
    mem_busy     = !clr && w_freeze;
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state       <= RUN;
      r_cnt         <= '0;
      r_stall_count <= '0;
    end else begin
      if (pc_ld_n && !(&r_stall_count)) r_stall_count <= r_stall_count + CNT_W'(1);
      // release cycle (MEM_WAIT, cnt=0) returns to RUN without re-checking mem_access
      if (r_state == RUN) begin
        if (mem_access && LONG) begin
          r_state <= MEM_WAIT;
          r_cnt   <= LOAD;
        end
      end else if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
      else r_state <= RUN;
    end
  end
  assign stall_count = r_stall_count;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench with directed vectors for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  logic clk = 0;
  logic clr;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_rs1_used, id_rs2_used, ex_mem_read, ex_br_taken, mem_access, mem_access_b;
  logic pc_ld_n, if_id_ld_n, id_ex_ld_n, ex_mem_ld_n, mem_wb_ld_n;
  logic if_id_flush, id_ex_flush, mem_wb_flush, mem_busy;
  logic [3:0] stall_count;
  logic b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_fl1, b_fl2, b_fl3, b_busy;
  logic [3:0] b_count;
  typedef struct {string nm; logic [13:0] v;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  bit done = 0;
  always #5 clk = ~clk;
  pipe_hazard_ctrl #(.MEM_LAT(3), .REG_ADDR_W(5), .CNT_W(4)) u_a (
    .clk(clk), .clr(clr), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken),
    .mem_access(mem_access), .pc_ld_n(pc_ld_n), .if_id_ld_n(if_id_ld_n), .id_ex_ld_n(id_ex_ld_n),
    .ex_mem_ld_n(ex_mem_ld_n), .mem_wb_ld_n(mem_wb_ld_n), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush), .mem_busy(mem_busy),
    .stall_count(stall_count));
  pipe_hazard_ctrl #(.MEM_LAT(2), .REG_ADDR_W(5), .CNT_W(4)) u_b (
    .clk(clk), .clr(clr), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken),
    .mem_access(mem_access_b), .pc_ld_n(b_pc), .if_id_ld_n(b_ifid), .id_ex_ld_n(b_idex),
    .ex_mem_ld_n(b_exmem), .mem_wb_ld_n(b_memwb), .if_id_flush(b_fl1), .id_ex_flush(b_fl2),
    .mem_wb_flush(b_fl3), .mem_busy(b_busy), .stall_count(b_count));
  localparam logic [4:0] LD_RST = 5'b11111, LD_NORM = 5'b00000, LD_LU = 5'b11000, LD_FRZ = 5'b11110;
  localparam logic [2:0] FL_NONE = 3'b000, FL_LU = 3'b010, FL_BR = 3'b110, FL_FRZ = 3'b001;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_in();
    {id_rs1, id_rs2, ex_rd} = '0;
    {id_rs1_used, id_rs2_used, ex_mem_read, ex_br_taken, mem_access, mem_access_b} = '0;
  endtask
  task automatic push(string nm, logic [4:0] ld, logic [2:0] fl, logic busy, logic [3:0] cnt, logic bb);
    exp_t e;
    e.nm = nm;
    e.v = {ld, fl, busy, cnt, bb};
    q.push_back(e);
  endtask
  task automatic set_lu();
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_rs1_used = 1;
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        exp_t e;
        logic [13:0] act;
        e = q.pop_front();
        act = {pc_ld_n, if_id_ld_n, id_ex_ld_n, ex_mem_ld_n, mem_wb_ld_n,
               if_id_flush, id_ex_flush, mem_wb_flush, mem_busy, stall_count, b_busy};
        n_chk++;
        if (act !== e.v) begin
          n_fail++;
          $display("FAIL %s: got ld_n=%b fl=%b busy=%b cnt=%0d b_busy=%b, want ld_n=%b fl=%b busy=%b cnt=%0d b_busy=%b",
                   e.nm, act[13:9], act[8:6], act[5], act[4:1], act[0],
                   e.v[13:9], e.v[8:6], e.v[5], e.v[4:1], e.v[0]);
        end
      end
    end
  end
  initial begin
    idle_in();
    clr = 1; mem_access = 1; mem_access_b = 1; ex_br_taken = 1;
    tick(); push("reset1", LD_RST, FL_NONE, 0, 0, 0);
    tick(); push("reset2", LD_RST, FL_NONE, 0, 0, 0);
    tick(); clr = 0; idle_in(); push("post_reset_run", LD_NORM, FL_NONE, 0, 0, 0);
    tick(); set_lu(); push("lu_rs1", LD_LU, FL_LU, 0, 0, 0);
    tick(); ex_mem_read = 0; push("lu_clear", LD_NORM, FL_NONE, 0, 1, 0);
    tick(); ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; push("lu_rd_zero", LD_NORM, FL_NONE, 0, 1, 0);
    tick(); ex_rd = 7; id_rs2 = 7; id_rs2_used = 1; id_rs1 = 3; push("lu_rs2", LD_LU, FL_LU, 0, 1, 0);
    tick(); id_rs2_used = 0; push("lu_rs2_unused", LD_NORM, FL_NONE, 0, 2, 0);
    tick(); id_rs2_used = 1; ex_br_taken = 1; push("branch_over_lu", LD_NORM, FL_BR, 0, 2, 0);
    tick(); idle_in(); push("after_branch", LD_NORM, FL_NONE, 0, 2, 0);
    tick(); mem_access = 1; push("mem_c1", LD_FRZ, FL_FRZ, 1, 2, 0);
    tick(); ex_br_taken = 1; push("mem_c2_br_ignored", LD_FRZ, FL_FRZ, 1, 3, 0);
    tick(); push("mem_c3_release_br", LD_NORM, FL_BR, 0, 4, 0);
    tick(); idle_in(); push("mem_no_reentry", LD_NORM, FL_NONE, 0, 4, 0);
    tick(); mem_access = 1; set_lu(); push("mem_lu_c1", LD_FRZ, FL_FRZ, 1, 4, 0);
    tick(); push("mem_lu_c2", LD_FRZ, FL_FRZ, 1, 5, 0);
    tick(); push("mem_lu_release", LD_LU, FL_LU, 0, 6, 0);
    tick(); idle_in(); push("mem_lu_after", LD_NORM, FL_NONE, 0, 7, 0);
    tick(); mem_access = 1; push("midwait_c1", LD_FRZ, FL_FRZ, 1, 7, 0);
    tick(); clr = 1; push("midwait_clr", LD_RST, FL_NONE, 0, 8, 0);
    tick(); clr = 0; idle_in(); push("midwait_after_clr", LD_NORM, FL_NONE, 0, 0, 0);
    tick(); mem_access_b = 1; push("b2b_freeze1", LD_NORM, FL_NONE, 0, 0, 1);
    tick(); push("b2b_release1", LD_NORM, FL_NONE, 0, 0, 0);
    tick(); push("b2b_freeze2", LD_NORM, FL_NONE, 0, 0, 1);
    tick(); mem_access_b = 0; push("b2b_release2", LD_NORM, FL_NONE, 0, 0, 0);
    tick(); push("b2b_idle", LD_NORM, FL_NONE, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      tick(); set_lu(); push($sformatf("sat_lu%0d", i), LD_LU, FL_LU, 0, 4'((i > 15) ? 15 : i), 0);
    end
    tick(); idle_in(); push("sat_hold1", LD_NORM, FL_NONE, 0, 15, 0);
    tick(); push("sat_hold2", LD_NORM, FL_NONE, 0, 15, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #2;
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
